// File: rtl/ofs_plat_hssi_tx_pkt_fifo.sv
// ofs_plat_hssi_tx_pkt_fifo: store-and-forward TX packet FIFO feeding one HSSI TX port.
// Ports: clk, reset_n (async, active-low); in_* AFU Avalon-ST sink; out_* HSSI TX
// source; pkt_cnt = committed unsent packets; drop_pulse = one pulse per discarded packet.
// Build option OFS_PLAT_HSSI_TX_FIFO_STATS_EN adds saturating stat_tx_pkts / stat_drops.
module ofs_plat_hssi_tx_pkt_fifo #(
   parameter int DATA_WIDTH    = 64,
   parameter int EMPTY_WIDTH   = 3,
   parameter int DEPTH_LOG2    = 9,
   parameter int MAX_PKTS_LOG2 = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_sop,
   input  logic                     in_eop,
   input  logic [EMPTY_WIDTH-1:0]   in_empty,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic [EMPTY_WIDTH-1:0]   out_empty,
   output logic [MAX_PKTS_LOG2:0]   pkt_cnt,
   output logic                     drop_pulse
`ifdef OFS_PLAT_HSSI_TX_FIFO_STATS_EN
   ,
   output logic [31:0]              stat_tx_pkts,
   output logic [31:0]              stat_drops
`endif
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam int CW = MAX_PKTS_LOG2 + 1;
   localparam int WW = DATA_WIDTH + EMPTY_WIDTH + 2;
   localparam int NW = 1 << DEPTH_LOG2;

   localparam logic [PW-1:0] DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PW-1:0] PONE     = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] MAX_PKTS = {1'b1, {MAX_PKTS_LOG2{1'b0}}};
   localparam logic [CW-1:0] CONE     = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCEPT = 2'd1;
   localparam logic [1:0] ST_DROP   = 2'd2;

   logic                rst_q;
   logic [1:0]          state_q, state_d;
   logic [PW-1:0]       swp_q, swp_d;
   logic [PW-1:0]       cwp_q, cwp_d;
   logic [PW-1:0]       rp_q;
   logic [PW-1:0]       wr_ptr;
   logic [CW-1:0]       pkt_cnt_q;
   logic [WW-1:0]       mem [0:NW-1];
   logic [WW-1:0]       wr_word;
   logic [WW-1:0]       rd_word;
   logic                full;
   logic                pkt_full;
   logic                in_fire;
   logic                out_fire;
   logic                out_done;
   logic                load;
   logic                wr_en;
   logic                commit;
   logic                drop;

   // Reset asserts with reset_n but releases on a clock edge, so in_ready
   // stays low for the cycle following deassertion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_q <= 1'b0;
      else          rst_q <= 1'b1;
   end

   assign full     = (swp_q - rp_q) == DEPTH;
   assign pkt_full = pkt_cnt_q == MAX_PKTS;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign out_done = out_fire && out_eop;
   assign pkt_cnt  = pkt_cnt_q;
   assign wr_word  = {in_sop, in_eop, in_empty, in_data};
   assign rd_word  = mem[rp_q[DEPTH_LOG2-1:0]];
   assign load     = (!out_valid || out_ready) && (rp_q != cwp_q);

   // Full with no committed packet means the open packet alone fills the
   // RAM: keep accepting so the overflow beat can trigger the drop.
   always_comb begin
      in_ready = 1'b0;
      if (rst_q) begin
         case (state_q)
            ST_IDLE:   in_ready = !pkt_full && !full;
            ST_ACCEPT: in_ready = !full || (pkt_cnt_q == '0);
            ST_DROP:   in_ready = 1'b1;
            default:   in_ready = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      swp_d   = swp_q;
      cwp_d   = cwp_q;
      wr_ptr  = swp_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      drop    = 1'b0;
      if (in_fire) begin
         case (state_q)
            ST_IDLE: begin
               if (in_sop) begin
                  wr_en = 1'b1;
                  swp_d = swp_q + PONE;
                  if (in_eop) begin
                     commit = 1'b1;
                     cwp_d  = swp_q + PONE;
                  end else begin
                     state_d = ST_ACCEPT;
                  end
               end
            end
            ST_ACCEPT: begin
               if (in_sop) begin
                  // Abandon the open packet; restart at the commit point.
                  drop   = 1'b1;
                  wr_en  = 1'b1;
                  wr_ptr = cwp_q;
                  swp_d  = cwp_q + PONE;
                  if (in_eop) begin
                     commit  = 1'b1;
                     cwp_d   = cwp_q + PONE;
                     state_d = ST_IDLE;
                  end
               end else if (full) begin
                  drop    = 1'b1;
                  swp_d   = cwp_q;
                  state_d = in_eop ? ST_IDLE : ST_DROP;
               end else begin
                  wr_en = 1'b1;
                  swp_d = swp_q + PONE;
                  if (in_eop) begin
                     commit  = 1'b1;
                     cwp_d   = swp_q + PONE;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DROP: begin
               if (in_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_q) begin
      if (!rst_q) begin
         state_q    <= ST_IDLE;
         swp_q      <= '0;
         cwp_q      <= '0;
         rp_q       <= '0;
         pkt_cnt_q  <= '0;
         drop_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         swp_q      <= swp_d;
         cwp_q      <= cwp_d;
         drop_pulse <= drop;
         if (load) rp_q <= rp_q + PONE;
         case ({commit, out_done})
            2'b10:   pkt_cnt_q <= pkt_cnt_q + CONE;
            2'b01:   pkt_cnt_q <= pkt_cnt_q - CONE;
            default: pkt_cnt_q <= pkt_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_q) begin
      if (!rst_q) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_empty <= '0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         {out_sop, out_eop, out_empty, out_data} <= rd_word;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OFS_PLAT_HSSI_TX_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst_q) begin
      if (!rst_q) begin
         stat_tx_pkts <= '0;
         stat_drops   <= '0;
      end else begin
         if (out_done && (stat_tx_pkts != '1))
            stat_tx_pkts <= stat_tx_pkts + 32'd1;
         if (drop_pulse && (stat_drops != '1))
            stat_drops <= stat_drops + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ofs_plat_hssi_tx_pkt_fifo.sv
// tb_ofs_plat_hssi_tx_pkt_fifo: table-driven cycle vectors plus directed
// packet sequences with a scoreboard for ofs_plat_hssi_tx_pkt_fifo.
module tb_ofs_plat_hssi_tx_pkt_fifo;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_sop;
   logic        in_eop;
   logic [2:0]  in_empty;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [2:0]  out_empty;
   logic [4:0]  pkt_cnt;
   logic        drop_pulse;
`ifdef OFS_PLAT_HSSI_TX_FIFO_STATS_EN
   logic [31:0] stat_tx_pkts;
   logic [31:0] stat_drops;
`endif

   always #5 clk = ~clk;

   ofs_plat_hssi_tx_pkt_fifo dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_empty   (in_empty),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_empty  (out_empty),
      .pkt_cnt    (pkt_cnt),
      .drop_pulse (drop_pulse)
`ifdef OFS_PLAT_HSSI_TX_FIFO_STATS_EN
      ,
      .stat_tx_pkts (stat_tx_pkts),
      .stat_drops   (stat_drops)
`endif
   );

   typedef struct {
      logic        iv, is, ie;
      logic [63:0] id;
      logic [2:0]  iem;
      logic        ordy;
      logic        e_irdy, e_ov;
      logic [63:0] e_od;
      logic        e_os, e_oe;
      logic [2:0]  e_oem;
      logic [4:0]  e_cnt;
      logic        e_drop;
   } vec_t;

   typedef struct packed {
      logic        s;
      logic        e;
      logic [2:0]  em;
      logic [63:0] d;
   } beat_t;

   localparam int NV = 14;
   vec_t  tbl [NV];
   beat_t expq [$];

   int    checks = 0;
   int    errors = 0;
   int    drops = 0;
   int    drop_at = 0;
   int    sent_beats = 0;
   logic  ready_req = 1'b0;
   logic  rnd_en = 1'b0;
   logic  rnd_bit = 1'b0;
   logic  mon_en = 1'b0;

   assign out_ready = rnd_en ? rnd_bit : ready_req;

   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   function automatic vec_t mk(
      input logic iv, is, ie, input logic [63:0] id, input logic [2:0] iem,
      input logic ordy, input logic irdy, ov, input logic [63:0] od,
      input logic os, oe, input logic [2:0] oem, input logic [4:0] cnt);
      vec_t v;
      v.iv = iv; v.is = is; v.ie = ie; v.id = id; v.iem = iem; v.ordy = ordy;
      v.e_irdy = irdy; v.e_ov = ov; v.e_od = od; v.e_os = os; v.e_oe = oe;
      v.e_oem = oem; v.e_cnt = cnt; v.e_drop = 1'b0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   // Scoreboard and hold-stability monitor.
   logic        hold = 1'b0;
   beat_t       hbeat;
   always @(negedge clk) begin
      beat_t b;
      if (!reset_n) begin
         hold = 1'b0;
      end else begin
         if (hold)
            chk("stable", {out_valid, out_sop, out_eop, out_empty, out_data},
                {1'b1, hbeat});
         hold  = out_valid && !out_ready;
         hbeat = {out_sop, out_eop, out_empty, out_data};
         if (mon_en && out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected beat got %0h exp none", out_data);
            end else begin
               b = expq.pop_front();
               chk("sb beat", {out_sop, out_eop, out_empty, out_data}, b);
            end
         end
         if (drop_pulse) begin
            drops++;
            drop_at = sent_beats;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the handshake.
   task automatic put(input logic [63:0] d, input logic s, input logic e,
                      input logic [2:0] em, input bit push);
      int n = 0;
      beat_t b;
      if (push) begin
         b.s = s; b.e = e; b.em = em; b.d = d;
         expq.push_back(b);
      end
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_empty = em;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 2000) begin
            checks++;
            errors++;
            $display("FAIL put timeout got in_ready 0 exp 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      sent_beats++;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((expq.size() != 0 || pkt_cnt != 0 || out_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(expq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      int first, last, cnt, d0, len;
      reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_data = '0; in_empty = '0;

      tbl[0]  = mk(1,1,1,64'hA5,3,1, 1,0,0,0,0,0,0);
      tbl[1]  = mk(0,0,0,0,0,1,      1,0,0,0,0,0,1);
      tbl[2]  = mk(0,0,0,0,0,1,      1,1,64'hA5,1,1,3,1);
      tbl[3]  = mk(0,0,0,0,0,1,      1,0,0,0,0,0,0);
      tbl[4]  = mk(1,1,0,64'h11,0,0, 1,0,0,0,0,0,0);
      tbl[5]  = mk(1,0,0,64'h22,0,0, 1,0,0,0,0,0,0);
      tbl[6]  = mk(1,0,1,64'h33,5,0, 1,0,0,0,0,0,0);
      tbl[7]  = mk(0,0,0,0,0,0,      1,0,0,0,0,0,1);
      tbl[8]  = mk(0,0,0,0,0,0,      1,1,64'h11,1,0,0,1);
      tbl[9]  = mk(0,0,0,0,0,0,      1,1,64'h11,1,0,0,1);
      tbl[10] = mk(0,0,0,0,0,1,      1,1,64'h11,1,0,0,1);
      tbl[11] = mk(0,0,0,0,0,1,      1,1,64'h22,0,0,0,1);
      tbl[12] = mk(0,0,0,0,0,1,      1,1,64'h33,0,1,5,1);
      tbl[13] = mk(0,0,0,0,0,1,      1,0,0,0,0,0,0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst pkt_cnt", pkt_cnt, 0);
      chk("rst drop", drop_pulse, 0);
      chk("rst out_data", out_data, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post-rst in_ready", in_ready, 0);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         in_valid = tbl[i].iv; in_sop = tbl[i].is; in_eop = tbl[i].ie;
         in_data = tbl[i].id; in_empty = tbl[i].iem; ready_req = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].e_irdy);
         chk($sformatf("v%0d out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("v%0d pkt_cnt", i), pkt_cnt, tbl[i].e_cnt);
         chk($sformatf("v%0d drop", i), drop_pulse, tbl[i].e_drop);
         if (tbl[i].e_ov)
            chk($sformatf("v%0d out_beat", i),
                {out_sop, out_eop, out_empty, out_data},
                {tbl[i].e_os, tbl[i].e_oe, tbl[i].e_oem, tbl[i].e_od});
      end

      // 16 x 8-beat packets under full backpressure.
      @(posedge clk);
      #1;
      in_valid = 1'b0; ready_req = 1'b0; mon_en = 1'b1;
      for (int p = 0; p < 16; p++)
         for (int b = 0; b < 8; b++)
            put(64'(p * 256 + b), b == 0, b == 7, (b == 7) ? 3'(p) : 3'd0, 1);
      @(negedge clk);
      chk("16pkt pkt_cnt", pkt_cnt, 16);
      chk("16pkt in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("16pkt in_ready held", in_ready, 0);
      @(posedge clk);
      #1 ready_req = 1'b1;
      first = -1; last = -1; cnt = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (first < 0) first = n;
            last = n;
            cnt++;
         end
      end
      chk("16pkt beats", 64'(cnt), 64'd128);
      chk("16pkt contiguous", 64'(last - first), 64'd127);
      wait_drain("16pkt drain");

      // Oversize packet: 600 beats into 512 words.
      sent_beats = 0;
      d0 = drops;
      for (int k = 1; k <= 600; k++)
         put(64'(k), k == 1, k == 600, 3'd0, 0);
      repeat (3) @(negedge clk);
      chk("oversize drops", 64'(drops - d0), 64'd1);
      chk("oversize drop beat", 64'(drop_at), 64'd513);
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++)
         put(64'hB000 + 64'(b), b == 0, b == 3, (b == 3) ? 3'd2 : 3'd0, 1);
      wait_drain("after oversize");

      // SOP arriving inside an open packet.
      d0 = drops;
      put(64'hA1, 1, 0, 0, 0);
      put(64'hA2, 0, 0, 0, 0);
      for (int b = 0; b < 4; b++)
         put(64'hC0 + 64'(b), b == 0, b == 3, (b == 3) ? 3'd7 : 3'd0, 1);
      repeat (3) @(negedge clk);
      chk("restart drops", 64'(drops - d0), 64'd1);
      wait_drain("restart drain");

      // Random sizes under random backpressure.
      rnd_en = 1'b1;
      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 64);
         for (int b = 0; b < len; b++)
            put({$urandom, $urandom}, b == 0, b == len - 1,
                (b == len - 1) ? 3'($urandom_range(0, 7)) : 3'd0, 1);
      end
      wait_drain("random drain");
      rnd_en = 1'b0;

      // Reset with three packets buffered and one open.
      ready_req = 1'b0;
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < 4; b++)
            put(64'hD00 + 64'(p * 16 + b), b == 0, b == 3, 3'd0, 0);
      put(64'hE0, 1, 0, 0, 0);
      put(64'hE1, 0, 0, 0, 0);
      @(negedge clk);
      chk("pre-reset pkt_cnt", pkt_cnt, 3);
      chk("pre-reset out_valid", out_valid, 1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("mid-reset out_valid", out_valid, 0);
      chk("mid-reset pkt_cnt", pkt_cnt, 0);
      chk("mid-reset in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int b = 0; b < 3; b++)
         put(64'hF0 + 64'(b), b == 0, b == 2, (b == 2) ? 3'd1 : 3'd0, 1);
      ready_req = 1'b1;
      wait_drain("post-reset drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
